// File: rtl/rca_seq_addsub_pkg.sv
// Shared types and helpers for the digit-serial ripple-carry adder/subtractor.
// Holds the FSM state encoding and the constant clog2 used to size the digit counter.
package rca_seq_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rca_seq_addsub_if.sv
// Operand/result bundle for rca_seq_addsub: request side drives the operands,
// the adder returns busy/done and the registered result.
interface rca_seq_addsub_if #(
   parameter int unsigned N = 16
);
   logic         start;
   logic         Sub;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Cin;
   logic         busy;
   logic         done;
   logic [N-1:0] S;
   logic         Cout;
   logic         V;

   modport master (
      output start, Sub, A, B, Cin,
      input  busy, done, S, Cout, V
   );

   modport slave (
      input  start, Sub, A, B, Cin,
      output busy, done, S, Cout, V
   );
endinterface

// File: rtl/rca_seq_addsub_digit.sv
// D-bit combinational ripple-carry slice built from full adders.
// Also exposes the carry into the slice MSB for signed-overflow detection.
module rca_digit #(
   parameter int unsigned D = 4
) (
   input  logic [D-1:0] a,
   input  logic [D-1:0] b,
   input  logic         ci,
   output logic [D-1:0] s,
   output logic         co,
   output logic         c_msb
);

   logic [D:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < int'(D); i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co    = c[D];
      c_msb = c[D-1];
   end

endmodule

// File: rtl/rca_seq_addsub.sv
// Digit-serial ripple-carry adder/subtractor: one D-bit digit per cycle,
// carry kept in a register between digits, start/busy/done handshake.
module rca_seq_addsub
   import rca_seq_addsub_pkg::*;
#(
   parameter int unsigned N = 16,
   parameter int unsigned D = 4
) (
   input  logic            clk,
   input  logic            rst,
   rca_seq_addsub_if.slave bus
);

   localparam int unsigned K  = N / D;
   localparam int unsigned IW = (clog2(K) > 0) ? clog2(K) : 1;

   generate
      if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_param
         $error("rca_seq_addsub: illegal N/D combination");
      end
   endgenerate

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [N-1:0]  opa_q, opa_d;
   logic [N-1:0]  opb_q, opb_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  res_q, res_d;
   logic [N-1:0]  s_q, s_d;
   logic          cout_q, cout_d;
   logic          v_q, v_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   int unsigned   base;
   logic [D-1:0]  dig_a, dig_b, dig_s;
   logic          dig_co, dig_cmsb;
   logic          last_digit;

   // Select the operand digit addressed by the counter.
   always_comb begin
      base       = 32'(idx_q) * D;
      dig_a      = opa_q[base +: D];
      dig_b      = opb_q[base +: D];
      last_digit = (idx_q == IW'(K - 1));
   end

   rca_digit #(.D(D)) u_digit (
      .a     (dig_a),
      .b     (dig_b),
      .ci    (carry_q),
      .s     (dig_s),
      .co    (dig_co),
      .c_msb (dig_cmsb)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      res_d   = res_q;
      s_d     = s_q;
      cout_d  = cout_q;
      v_d     = v_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               // Subtraction is A + ~B + ~Cin, so invert B and the carry at load time.
               opa_d   = bus.A;
               opb_d   = bus.Sub ? ~bus.B : bus.B;
               carry_d = bus.Sub ^ bus.Cin;
               idx_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            res_d[base +: D] = dig_s;
            carry_d          = dig_co;
            if (last_digit) begin
               s_d     = res_d;
               cout_d  = dig_co;
               v_d     = dig_cmsb ^ dig_co;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.S    = s_q;
   assign bus.Cout = cout_q;
   assign bus.V    = v_q;

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Scoreboard bench for rca_seq_addsub: directed handshake cases on D=4,
// random regression on D=1 and D=16 against an arithmetic reference model.
module tb_rca_seq_addsub;

   localparam int unsigned N = 16;

   typedef struct packed {
      logic [N-1:0] s;
      logic         cout;
      logic         v;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rca_seq_addsub_if #(.N(N)) if4 ();
   rca_seq_addsub_if #(.N(N)) if1 ();
   rca_seq_addsub_if #(.N(N)) if16 ();

   rca_seq_addsub #(.N(N), .D(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
   rca_seq_addsub #(.N(N), .D(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));
   rca_seq_addsub #(.N(N), .D(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

   res_t q4[$];
   res_t q1[$];
   res_t q16[$];
   int   checks = 0;
   int   passes = 0;

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endfunction

   // Plain integer arithmetic: unsigned range gives carry/borrow, signed range gives overflow.
   function automatic res_t ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic cin, input logic sub);
      longint ua, ub, sa, sb, u, sv, maxs, mins;
      res_t   r;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      maxs = (longint'(1) <<< (N - 1)) - 1;
      mins = -(longint'(1) <<< (N - 1));
      if (!sub) begin
         u      = ua + ub + longint'(cin);
         sv     = sa + sb + longint'(cin);
         r.cout = (u >= (longint'(1) <<< N));
      end else begin
         u      = ua - ub - longint'(cin);
         sv     = sa - sb - longint'(cin);
         r.cout = (u >= 0);
      end
      r.s = N'(u);
      r.v = (sv > maxs) || (sv < mins);
      return r;
   endfunction

   // Scoreboard monitors: pop one expectation per done pulse.
   always @(negedge clk) if (!rst && if4.done) begin
      res_t e;
      if (q4.size() == 0) check("d4_unexpected_done", 64'(1), 64'(0));
      else begin
         e = q4.pop_front();
         check("d4_result", 64'({if4.S, if4.Cout, if4.V}), 64'(e));
      end
   end

   always @(negedge clk) if (!rst && if1.done) begin
      res_t e;
      if (q1.size() == 0) check("d1_unexpected_done", 64'(1), 64'(0));
      else begin
         e = q1.pop_front();
         check("d1_result", 64'({if1.S, if1.Cout, if1.V}), 64'(e));
      end
   end

   always @(negedge clk) if (!rst && if16.done) begin
      res_t e;
      if (q16.size() == 0) check("d16_unexpected_done", 64'(1), 64'(0));
      else begin
         e = q16.pop_front();
         check("d16_result", 64'({if16.S, if16.Cout, if16.V}), 64'(e));
      end
   end

   // One D=4 operation; b2b drives start straight away (used from inside the DONE cycle).
   task automatic op4(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                      input logic sub, input res_t exp, input bit b2b);
      int lat;
      int bc;
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      if4.A = a; if4.B = b; if4.Cin = cin; if4.Sub = sub; if4.start = 1'b1;
      q4.push_back(exp);
      lat = 0;
      bc  = 0;
      do begin
         @(posedge clk);
         lat++;
         #1 if4.start = 1'b0;
         @(negedge clk);
         if (if4.busy) bc++;
      end while (!if4.done && lat < 60);
      check("d4_latency", 64'(lat), 64'(5));
      check("d4_busy_cycles", 64'(bc), 64'(4));
   endtask

   task automatic wait_done4();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!if4.done && n < 60);
      if (n >= 60) check("d4_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      {if4.start, if4.Sub, if4.A, if4.B, if4.Cin}    = '0;
      {if1.start, if1.Sub, if1.A, if1.B, if1.Cin}    = '0;
      {if16.start, if16.Sub, if16.A, if16.B, if16.Cin} = '0;
      repeat (2) @(negedge clk);
      check("reset_d4",  64'({if4.busy, if4.done, if4.S, if4.Cout, if4.V}), 64'(0));
      check("reset_d1",  64'({if1.busy, if1.done, if1.S, if1.Cout, if1.V}), 64'(0));
      check("reset_d16", 64'({if16.busy, if16.done, if16.S, if16.Cout, if16.V}), 64'(0));
      rst = 1'b0;

      // Directed arithmetic cases with hand-computed results.
      op4(16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0}, 1'b0);
      op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 1'b0);
      op4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}, 1'b0);
      op4(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 1'b0);
      op4(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, 1'b0);

      // start re-pulsed mid-RUN with different operands must be ignored.
      @(posedge clk);
      #1 if4.A = 16'h1234; if4.B = 16'h1111; if4.Cin = 1'b0; if4.Sub = 1'b0; if4.start = 1'b1;
      q4.push_back('{16'h2345, 1'b0, 1'b0});
      @(posedge clk);
      #1 if4.start = 1'b0;
      @(posedge clk);
      #1 if4.A = 16'hFFFF; if4.start = 1'b1;
      @(posedge clk);
      #1 if4.start = 1'b0;
      wait_done4();
      repeat (8) @(negedge clk);

      // Back-to-back: start held in the DONE cycle re-enters RUN.
      op4(16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}, 1'b0);
      op4(16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}, 1'b1);
      repeat (3) @(negedge clk);

      // Reset during the second RUN cycle aborts without a done pulse.
      @(posedge clk);
      #1 if4.A = 16'h1234; if4.B = 16'h1111; if4.Cin = 1'b0; if4.Sub = 1'b0; if4.start = 1'b1;
      @(posedge clk);
      #1 if4.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      q4.delete();
      #1 check("d4_reset_mid_run", 64'({if4.busy, if4.done, if4.S, if4.Cout, if4.V}), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      op4(16'hAAAA, 16'h5555, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}, 1'b0);

      // Random regression on the two extreme digit widths.
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [N-1:0] a, b;
               logic         c, s;
               int           lat;
               a = N'($urandom); b = N'($urandom); c = 1'($urandom); s = 1'($urandom);
               @(posedge clk);
               #1 if1.A = a; if1.B = b; if1.Cin = c; if1.Sub = s; if1.start = 1'b1;
               q1.push_back(ref_model(a, b, c, s));
               lat = 0;
               do begin
                  @(posedge clk);
                  lat++;
                  #1 if1.start = 1'b0;
                  @(negedge clk);
               end while (!if1.done && lat < 60);
               check("d1_latency", 64'(lat), 64'(17));
            end
         end
         begin
            for (int i = 0; i < 1000; i++) begin
               logic [N-1:0] a, b;
               logic         c, s;
               int           lat;
               a = N'($urandom); b = N'($urandom); c = 1'($urandom); s = 1'($urandom);
               @(posedge clk);
               #1 if16.A = a; if16.B = b; if16.Cin = c; if16.Sub = s; if16.start = 1'b1;
               q16.push_back(ref_model(a, b, c, s));
               lat = 0;
               do begin
                  @(posedge clk);
                  lat++;
                  #1 if16.start = 1'b0;
                  @(negedge clk);
               end while (!if16.done && lat < 60);
               check("d16_latency", 64'(lat), 64'(2));
            end
         end
      join

      repeat (3) @(negedge clk);
      check("queues_drained", 64'(q4.size() + q1.size() + q16.size()), 64'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
